axi_sram_responder: RTL and testbench
=====================================

# axi_sram_responder

AXI4 slave endpoint that terminates bursts issued by the interconnect's master ports, backing them with an on-chip single-port byte-writable SRAM. Accepts one transaction at a time (read or write), runs INCR/FIXED bursts up to 256 beats, and returns standard B/R responses. Used as scratch memory behind `axi_bus_m1`; it also serves as the bench target for interconnect verification.

## Interface
- DATA_WIDTH, 32, data bus width in bits; only 32 is supported.
- MEM_WORDS_LOG2, 10, log2 of SRAM depth in 32-bit words (default 4 KiB).
- BASE_ADDRESS, 32'h0, byte address mapped to word 0.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- awaddr/awlen/awsize/awburst/awvalid  in  32/8/3/2/1  write address channel.
- awready  out  1  write address accept.
- wdata/wstrb/wlast/wvalid  in  32/4/1/1  write data channel.
- wready  out  1  write data accept.
- bresp/bvalid  out  2/1  write response; bready  in  1.
- araddr/arlen/arsize/arburst/arvalid  in  32/8/3/2/1  read address channel.
- arready  out  1  read address accept.
- rdata/rresp/rlast/rvalid  out  32/2/1/1  read data channel; rready  in  1.

## Operation
- FSM states: IDLE, WRITE_BURST, WRITE_RESP, READ_BURST.
- IDLE: awready=1 and arready=1 only when the other channel's valid is low or arbitration grants it. If both awvalid and arvalid are high, grant round-robin: a 1-bit last_grant flop (reset = read) selects write if the last grant was read, else read. Only one of awready/arready is high per cycle.
- AW handshake: latch word index = (awaddr - BASE_ADDRESS) >> 2, beats_left = awlen, burst type; go to WRITE_BURST.
- WRITE_BURST: wready=1. Each W handshake writes bytes whose wstrb bit is set, then advances the index (INCR: +1 modulo 2^MEM_WORDS_LOG2; FIXED: unchanged; WRAP (2'b10) is treated as INCR). When beats_left==0 on a handshake, go to WRITE_RESP.
- wlast mismatch (wlast on a beat other than the last, or missing on the last): beat count still governs termination; set err flag.
- Out of range: if (addr - BASE_ADDRESS) >= 4<<MEM_WORDS_LOG2 at the AW/AR handshake, the whole burst is an error: writes are suppressed, reads return 0.
- WRITE_RESP: bvalid=1, bresp = err ? 2'b10 (SLVERR) : 2'b00; hold until bready, then IDLE and clear err.
- READ_BURST: AR handshake latches index/beats_left/type as above. SRAM read enable = beats_to_issue>0 && (!rvalid || rready). rdata is the SRAM output register, held while the enable is low. rlast=1 on the beat with beats_left==0; rresp = SLVERR for an out-of-range burst, else OKAY. The R handshake on rlast goes to IDLE.
- awsize/arsize are ignored; every beat is a full 32-bit word.
- Reset (at any time, including mid-burst): state IDLE, last_grant=read, err=0, all counters 0, outputs awready=arready=wready=bvalid=rvalid=rlast=0, bresp=rresp=0, rdata=0. SRAM contents are not reset.

## Timing
- awready/arready are combinational from state and valids; there is no same-cycle dependency of valid on ready.
- Write: the first wready is in the cycle after the AW handshake. Beats are back-to-back at 1/cycle. bvalid is in the cycle after the last W handshake.
- Read: the first rvalid is 2 cycles after the AR handshake (1 cycle to issue, 1 cycle of SRAM latency). Then 1 beat/cycle while rready=1. When rready=0, rvalid/rdata/rlast hold stable, with no data loss or duplication.
- Back-to-back transactions: after the final B or R handshake, IDLE accepts a new address in the next cycle. Minimum gap is 1 cycle.
- A 256-beat burst (len=255) terminates correctly. The index wraps from 2^MEM_WORDS_LOG2-1 to 0.

## Structure
- Shared package axi_pkg: burst encodings (FIXED=2'b00, INCR=2'b01, WRAP=2'b10), resp encodings (OKAY=2'b00, SLVERR=2'b10), and the responder state enum.
- Sub-module axi_sram_ram: single-port synchronous RAM with 4-bit byte enable, read enable, and 1-cycle registered read output that holds when the enable is low. It is inferable as block RAM.
- The top level holds the FSM, arbitration, counters and error flag.

## Test plan
- Write awaddr=0x10, awlen=3, INCR, data 0xA0..0xA3, wstrb=4'hF; then read the same address -> bresp=OKAY, then 4 beats 0xA0..0xA3 with rlast only on beat 3, and the first rvalid 2 cycles after arready.
- Partial strobe: write 0xFFFFFFFF to word 0, then write 0x12345678 with wstrb=4'b0101 -> read returns 0xFF34FF78.
- rready toggled 1-0-0-1 during an 8-beat read -> every beat is delivered exactly once, in order, with rdata stable while stalled.
- awvalid and arvalid both high in IDLE, twice in succession -> the first grant is write, the second is read (round-robin from reset).
- Out-of-range araddr=BASE+0x1000 (len=1) -> 2 beats, rdata=0, rresp=2'b10. A write with an early wlast -> bresp=2'b10.
- Assert reset mid-write (beat 2 of 4) -> all outputs are 0 in the next cycle, IDLE accepts a new AW after reset deasserts, and beats 0–1 remain in memory.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI encodings and responder state for the SRAM endpoint.
// Imported by the responder top and its bench.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE_BURST,
    ST_WRITE_RESP,
    ST_READ_BURST
  } rsp_state_e;

endpackage

// File: rtl/axi_sram_ram.sv
// Single-port byte-writable SRAM with a registered read port
// that holds its last value while the read enable is low.
module axi_sram_ram #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            ren,
  input  logic            we,
  input  logic [DW/8-1:0] be,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (ren) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_sram_responder.sv
// AXI4 slave backed by on-chip SRAM; one read or write burst at a time,
// INCR/FIXED up to 256 beats, round-robin AW/AR arbitration.
module axi_sram_responder
  import axi_pkg::*;
#(
  parameter int          DATA_WIDTH     = 32,
  parameter int          MEM_WORDS_LOG2 = 10,
  parameter logic [31:0] BASE_ADDRESS   = 32'h0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [31:0]             araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int IW = MEM_WORDS_LOG2;

  rsp_state_e    state_q, state_d;
  logic          last_wr_q, last_wr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    beats_q, beats_d;
  logic [8:0]    issue_q, issue_d;
  logic          fixed_q, fixed_d;
  logic          oor_q, oor_d;
  logic          err_q, err_d;
  logic          rvalid_q, rvalid_d;
  logic          rlast_q, rlast_d;

  logic [31:0]   aw_off, ar_off;
  logic          aw_oor, ar_oor;
  logic          aw_pick, st_idle;
  logic          ren, ram_we;
  logic [IW-1:0] next_idx;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic          unused_bits;

  assign aw_off = awaddr - BASE_ADDRESS;
  assign ar_off = araddr - BASE_ADDRESS;
  assign aw_oor = |aw_off[31:IW+2];
  assign ar_oor = |ar_off[31:IW+2];
  assign unused_bits = ^{awsize, arsize, aw_off[1:0], ar_off[1:0]};

  // Write wins a tie only when the previous grant went to read.
  assign aw_pick = !arvalid || (awvalid && !last_wr_q);
  assign st_idle = (state_q == ST_IDLE) && !reset;
  assign awready = st_idle && aw_pick;
  assign arready = st_idle && !aw_pick;

  assign wready  = (state_q == ST_WRITE_BURST);
  assign bvalid  = (state_q == ST_WRITE_RESP);
  assign bresp   = (bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;

  assign ren = (state_q == ST_READ_BURST) && (issue_q != 9'd0)
             && (!rvalid_q || rready);
  assign ram_we   = wready && wvalid && !oor_q;
  assign next_idx = fixed_q ? idx_q : idx_q + 1'b1;

  assign rvalid = rvalid_q;
  assign rlast  = rvalid_q && rlast_q;
  assign rdata  = (rvalid_q && !oor_q) ? ram_rdata : '0;
  assign rresp  = (rvalid_q && oor_q) ? RESP_SLVERR : RESP_OKAY;

  axi_sram_ram #(
    .AW (IW),
    .DW (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .ren   (ren),
    .we    (ram_we),
    .be    (wstrb),
    .addr  (idx_q),
    .wdata (wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    idx_d     = idx_q;
    beats_d   = beats_q;
    issue_d   = issue_q;
    fixed_d   = fixed_q;
    oor_d     = oor_q;
    err_d     = err_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    unique case (state_q)
      ST_IDLE: begin
        if (awvalid && awready) begin
          state_d   = ST_WRITE_BURST;
          last_wr_d = 1'b1;
          idx_d     = aw_off[IW+1:2];
          beats_d   = awlen;
          fixed_d   = (awburst == BURST_FIXED);
          oor_d     = aw_oor;
          err_d     = aw_oor;
        end else if (arvalid && arready) begin
          state_d   = ST_READ_BURST;
          last_wr_d = 1'b0;
          idx_d     = ar_off[IW+1:2];
          issue_d   = {1'b0, arlen} + 9'd1;
          fixed_d   = (arburst == BURST_FIXED);
          oor_d     = ar_oor;
          err_d     = ar_oor;
        end
      end
      ST_WRITE_BURST: begin
        if (wvalid) begin
          idx_d   = next_idx;
          beats_d = beats_q - 8'd1;
          if (wlast != (beats_q == 8'd0)) err_d = 1'b1;
          if (beats_q == 8'd0) state_d = ST_WRITE_RESP;
        end
      end
      ST_WRITE_RESP: begin
        if (bready) begin
          state_d = ST_IDLE;
          err_d   = 1'b0;
          oor_d   = 1'b0;
        end
      end
      ST_READ_BURST: begin
        if (ren) begin
          idx_d    = next_idx;
          issue_d  = issue_q - 9'd1;
          rlast_d  = (issue_q == 9'd1);
          rvalid_d = 1'b1;
        end else if (rready) begin
          rvalid_d = 1'b0;
        end
        if (rvalid_q && rready && rlast_q) begin
          state_d  = ST_IDLE;
          err_d    = 1'b0;
          oor_d    = 1'b0;
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      last_wr_q <= 1'b0;
      idx_q     <= '0;
      beats_q   <= '0;
      issue_q   <= '0;
      fixed_q   <= 1'b0;
      oor_q     <= 1'b0;
      err_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      idx_q     <= idx_d;
      beats_q   <= beats_d;
      issue_q   <= issue_d;
      fixed_q   <= fixed_d;
      oor_q     <= oor_d;
      err_q     <= err_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
    end
  end

endmodule

// File: tb/tb_axi_sram_responder.sv
// Scoreboard bench for axi_sram_responder: directed bursts push expected
// B/R responses, a negedge monitor pops and compares them.
module tb_axi_sram_responder;
  import axi_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic        bvalid, bready, arvalid, arready;
  logic        rlast, rvalid, rready;

  always #5 clk = ~clk;

  axi_sram_responder dut (
    .clk     (clk),
    .reset   (reset),
    .awaddr  (awaddr),
    .awlen   (awlen),
    .awsize  (awsize),
    .awburst (awburst),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wlast   (wlast),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .araddr  (araddr),
    .arlen   (arlen),
    .arsize  (arsize),
    .arburst (arburst),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rlast   (rlast),
    .rvalid  (rvalid),
    .rready  (rready)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
    logic        l;
  } rbeat_t;

  rbeat_t     exp_r[$];
  logic [1:0] exp_b[$];
  rbeat_t     er;
  logic [1:0] eb;
  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out", nm);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bvalid && bready) begin
        if (exp_b.size() == 0) fail("b_unexpected");
        else begin
          eb = exp_b.pop_front();
          check("bresp", bresp, eb);
        end
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) fail("r_unexpected");
        else begin
          er = exp_r.pop_front();
          check("rbeat", {rdata, rresp, rlast}, er);
        end
      end
    end
  end

  task automatic push_r(input int len, input logic [31:0] d0,
                        input int step, input logic [1:0] resp);
    for (int i = 0; i <= len; i++) begin
      exp_r.push_back('{d: d0 + step * i, r: resp, l: (i == len)});
    end
  endtask

  task automatic aw_phase(input logic [31:0] a, input logic [7:0] len,
                          input logic [1:0] bt);
    bit ok = 0;
    awaddr = a; awlen = len; awburst = bt; awvalid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (awready) begin ok = 1; break; end
    end
    if (!ok) fail("aw_accept");
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic w_phase(input int len, input logic [31:0] d0,
                         input logic [3:0] strb, input int last_at,
                         input int stop_at);
    for (int i = 0; i <= len; i++) begin
      bit ok;
      int waited;
      if (i == stop_at) return;
      ok = 0; waited = 0;
      wvalid = 1'b1; wdata = d0 + i; wstrb = strb;
      wlast = (i == last_at);
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (wready) begin ok = 1; break; end
        waited++;
      end
      if (!ok) fail("w_accept");
      if (i == 0) check("wready_lat", waited, 0);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_wait();
    bit ok = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bvalid) begin ok = 1; break; end
    end
    if (!ok) fail("b_wait");
    @(posedge clk); #1;
  endtask

  task automatic ar_phase(input logic [31:0] a, input logic [7:0] len);
    bit ok = 0;
    araddr = a; arlen = len; arburst = BURST_INCR; arvalid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (arready) begin ok = 1; break; end
    end
    if (!ok) fail("ar_accept");
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic r_phase(input bit stall);
    bit done = 0;
    logic [3:0] pat = 4'b1001;
    for (int c = 0; c < 1200; c++) begin
      rready = stall ? pat[c % 4] : 1'b1;
      @(negedge clk);
      if (c == 0) check("r_lat_c1", rvalid, 0);
      if (c == 1) check("r_lat_c2", rvalid, 1);
      if (rvalid && rready && rlast) done = 1;
      @(posedge clk); #1;
      if (done) break;
    end
    rready = 1'b1;
    if (!done) fail("r_done");
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    awaddr = '0; awlen = '0; awsize = 3'd2; awburst = BURST_INCR;
    awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b1;
    araddr = '0; arlen = '0; arsize = 3'd2; arburst = BURST_INCR;
    arvalid = 1'b0;
    rready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {awready, arready, wready, bvalid, rvalid, rlast,
                         bresp, rresp, rdata}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // arbitration: write first after reset, then read
    awaddr = 32'h40; awlen = 0; awburst = BURST_INCR;
    araddr = 32'h40; arlen = 0; arburst = BURST_INCR;
    awvalid = 1'b1; arvalid = 1'b1;
    @(negedge clk);
    check("arb_first", {awready, arready}, 2'b10);
    @(posedge clk); #1;
    awvalid = 1'b0; arvalid = 1'b0;
    exp_b.push_back(RESP_OKAY);
    w_phase(0, 32'h5A5A0000, 4'hF, 0, -1);
    b_wait();
    awaddr = 32'h44; awvalid = 1'b1; arvalid = 1'b1;
    @(negedge clk);
    check("arb_second", {awready, arready}, 2'b01);
    @(posedge clk); #1;
    awvalid = 1'b0; arvalid = 1'b0;
    push_r(0, 32'h5A5A0000, 0, RESP_OKAY);
    r_phase(0);

    // 4-beat INCR write then read back
    exp_b.push_back(RESP_OKAY);
    aw_phase(32'h10, 3, BURST_INCR);
    w_phase(3, 32'hA0, 4'hF, 3, -1);
    b_wait();
    push_r(3, 32'hA0, 1, RESP_OKAY);
    ar_phase(32'h10, 3);
    r_phase(0);

    // partial strobe
    exp_b.push_back(RESP_OKAY);
    aw_phase(32'h0, 0, BURST_INCR);
    w_phase(0, 32'hFFFFFFFF, 4'hF, 0, -1);
    b_wait();
    exp_b.push_back(RESP_OKAY);
    aw_phase(32'h0, 0, BURST_INCR);
    w_phase(0, 32'h12345678, 4'b0101, 0, -1);
    b_wait();
    push_r(0, 32'hFF34FF78, 0, RESP_OKAY);
    ar_phase(32'h0, 0);
    r_phase(0);

    // 8-beat read with rready stalls
    exp_b.push_back(RESP_OKAY);
    aw_phase(32'h300, 7, BURST_INCR);
    w_phase(7, 32'hD0, 4'hF, 7, -1);
    b_wait();
    push_r(7, 32'hD0, 1, RESP_OKAY);
    ar_phase(32'h300, 7);
    r_phase(1);

    // out-of-range read, early wlast, out-of-range write suppressed
    push_r(1, 32'h0, 0, RESP_SLVERR);
    ar_phase(32'h1000, 1);
    r_phase(0);
    exp_b.push_back(RESP_SLVERR);
    aw_phase(32'h200, 2, BURST_INCR);
    w_phase(2, 32'h70, 4'hF, 0, -1);
    b_wait();
    exp_b.push_back(RESP_SLVERR);
    aw_phase(32'h1010, 0, BURST_INCR);
    w_phase(0, 32'hBAD, 4'hF, 0, -1);
    b_wait();
    push_r(0, 32'hA0, 0, RESP_OKAY);
    ar_phase(32'h10, 0);
    r_phase(0);

    // index wrap at the top of memory
    exp_b.push_back(RESP_OKAY);
    aw_phase(32'hFFC, 1, BURST_INCR);
    w_phase(1, 32'hE0, 4'hF, 1, -1);
    b_wait();
    push_r(1, 32'hE0, 1, RESP_OKAY);
    ar_phase(32'hFFC, 1);
    r_phase(0);
    push_r(0, 32'hE1, 0, RESP_OKAY);
    ar_phase(32'h0, 0);
    r_phase(0);

    // FIXED burst keeps the last beat
    exp_b.push_back(RESP_OKAY);
    aw_phase(32'h20, 2, BURST_FIXED);
    w_phase(2, 32'hF0, 4'hF, 2, -1);
    b_wait();
    push_r(0, 32'hF2, 0, RESP_OKAY);
    ar_phase(32'h20, 0);
    r_phase(0);

    // 256-beat burst
    exp_b.push_back(RESP_OKAY);
    aw_phase(32'h800, 255, BURST_INCR);
    w_phase(255, 32'h10000000, 4'hF, 255, -1);
    b_wait();
    push_r(255, 32'h10000000, 1, RESP_OKAY);
    ar_phase(32'h800, 255);
    r_phase(0);

    // reset in the middle of a write burst
    aw_phase(32'h100, 3, BURST_INCR);
    w_phase(3, 32'hC0, 4'hF, 3, 2);
    reset = 1'b1; wvalid = 1'b0; wlast = 1'b0;
    @(negedge clk);
    check("midreset_outs", {awready, arready, wready, bvalid, rvalid, rlast,
                            bresp, rresp, rdata}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_b.push_back(RESP_OKAY);
    aw_phase(32'h180, 0, BURST_INCR);
    w_phase(0, 32'h77, 4'hF, 0, -1);
    b_wait();
    push_r(1, 32'hC0, 1, RESP_OKAY);
    ar_phase(32'h100, 1);
    r_phase(0);

    repeat (3) @(posedge clk);
    check("leftover", exp_r.size() + exp_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
